// File: rtl/fpu_arbiter_if.sv
// Signal bundle between the FPU arbiter, its two clients and the shared FPU.
// slave is the arbiter's view; master is the surrounding environment's view.
interface fpu_arbiter_if;
  logic        req0, req1;
  logic [31:0] a0, b0, a1, b1;
  logic [1:0]  op0, op1;
  logic        gnt0, gnt1;
  logic [31:0] r0, r1;
  logic        done0, done1;
  logic        err0, err1;
  logic        busy;
  logic [31:0] fpu_A, fpu_B;
  logic [1:0]  fpu_op;
  logic        fpu_start;
  logic [31:0] fpu_R;
  logic        fpu_done;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, op0, op1, fpu_R, fpu_done,
    output gnt0, gnt1, r0, r1, done0, done1, err0, err1, busy,
           fpu_A, fpu_B, fpu_op, fpu_start
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, op0, op1, fpu_R, fpu_done,
    input  gnt0, gnt1, r0, r1, done0, done1, err0, err1, busy,
           fpu_A, fpu_B, fpu_op, fpu_start
  );
endinterface

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FPU between two clients; waits for the FPU
// done edge with a cycle timeout and returns the result to the owning client.
module fpu_arbiter #(
  parameter int TIMEOUT = 2000,
  parameter int CW      = 11
) (
  input logic          clk,
  input logic          reset,
  fpu_arbiter_if.slave bus
);
  localparam logic [31:0]   QNAN     = 32'h7FC0_0000;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic          owner, owner_nxt;
  logic          last, last_nxt;
  logic          done_d;
  logic          done_rise;
  logic          sel;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   fa, fa_nxt, fb, fb_nxt;
  logic [1:0]    fop, fop_nxt;
  logic [31:0]   r0, r0_nxt, r1, r1_nxt;
  logic [1:0]    gnt, gnt_nxt;
  logic [1:0]    done, done_nxt;
  logic [1:0]    err, err_nxt;
  logic          start, start_nxt;
  logic          busy, busy_nxt;

  assign done_rise = bus.fpu_done & ~done_d;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    cnt_nxt   = cnt;
    fa_nxt    = fa;
    fb_nxt    = fb;
    fop_nxt   = fop;
    r0_nxt    = r0;
    r1_nxt    = r1;
    gnt_nxt   = gnt;
    done_nxt  = 2'b00;
    err_nxt   = 2'b00;
    start_nxt = 1'b0;
    sel       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the client that was not served last wins.
          sel       = (bus.req0 && bus.req1) ? ~last : bus.req1;
          owner_nxt = sel;
          fa_nxt    = sel ? bus.a1  : bus.a0;
          fb_nxt    = sel ? bus.b1  : bus.b0;
          fop_nxt   = sel ? bus.op1 : bus.op0;
          gnt_nxt   = sel ? 2'b10 : 2'b01;
          start_nxt = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (done_rise) begin
          if (owner) r1_nxt = bus.fpu_R;
          else       r0_nxt = bus.fpu_R;
          done_nxt  = owner ? 2'b10 : 2'b01;
          state_nxt = RESP;
        end else if (cnt == CNT_LAST) begin
          if (owner) r1_nxt = QNAN;
          else       r0_nxt = QNAN;
          done_nxt  = owner ? 2'b10 : 2'b01;
          err_nxt   = owner ? 2'b10 : 2'b01;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RESP: begin
        last_nxt  = owner;
        gnt_nxt   = 2'b00;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      cnt    <= '0;
      done_d <= 1'b0;
      fa     <= '0;
      fb     <= '0;
      fop    <= '0;
      r0     <= '0;
      r1     <= '0;
      gnt    <= '0;
      done   <= '0;
      err    <= '0;
      start  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      last   <= last_nxt;
      cnt    <= cnt_nxt;
      done_d <= bus.fpu_done;
      fa     <= fa_nxt;
      fb     <= fb_nxt;
      fop    <= fop_nxt;
      r0     <= r0_nxt;
      r1     <= r1_nxt;
      gnt    <= gnt_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
      start  <= start_nxt;
      busy   <= busy_nxt;
    end
  end

  assign bus.gnt0      = gnt[0];
  assign bus.gnt1      = gnt[1];
  assign bus.done0     = done[0];
  assign bus.done1     = done[1];
  assign bus.err0      = err[0];
  assign bus.err1      = err[1];
  assign bus.r0        = r0;
  assign bus.r1        = r1;
  assign bus.busy      = busy;
  assign bus.fpu_A     = fa;
  assign bus.fpu_B     = fb;
  assign bus.fpu_op    = fop;
  assign bus.fpu_start = start;
endmodule
